fw_ram_acl: RTL and testbench
=============================

Name: fw_ram_acl

Overview:
- Parametrised firmware RAM, successor to the fixed 512 x 32 FW RAM.
- Adds per-byte write enables, a registered read with a one-cycle ready handshake, and mode-based access control with violation reporting.
- Hardware zeroization runs after reset and on request.
- Sits on the CPU memory bus next to ROM; only firmware (system_mode = 0) may access it.

Parameters:
- DEPTH, 512, number of words; any value 2..2**ADDR_WIDTH.
- ADDR_WIDTH, 9, word address width.
- DATA_WIDTH, 32, word width; must be a multiple of 8.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- system_mode  input  1  0 = firmware mode (access allowed), 1 = application mode (access denied).
- cs  input  1  request strobe; master holds it high until ready is seen.
- we  input  DATA_WIDTH/8  per-byte write enables; all zero = read.
- address  input  ADDR_WIDTH  word address.
- write_data  input  DATA_WIDTH  write data.
- zeroize  input  1  single-cycle request to clear the whole memory.
- read_data  output  DATA_WIDTH  registered read data; valid while ready = 1.
- ready  output  1  one-cycle acknowledge.
- busy  output  1  high while a clear sweep is running.
- access_violation  output  1  one-cycle pulse, coincident with ready, on a denied access.
- parity_error  output  1  one-cycle pulse, coincident with ready (see Optional Feature).

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - ready = 0, read_data = 0, access_violation = 0, parity_error = 0.
  - busy = 1; clear counter = 0; state = CLEAR.
- States: CLEAR, IDLE, ACK.
- CLEAR:
  - Each cycle, write 0 to word[counter] and increment counter.
  - When counter = DEPTH-1 is written, go to IDLE next cycle; busy deasserts on entry to IDLE.
  - The sweep takes exactly DEPTH cycles.
  - cs is not acknowledged during CLEAR; the request stays pending, ready = 0.
- IDLE, zeroize = 1 (priority over cs):
  - Only honoured when system_mode = 0; go to CLEAR with counter = 0.
  - A pending cs waits until the sweep completes.
  - zeroize with system_mode = 1 is ignored silently.
- IDLE, cs = 1: the access is allowed when system_mode = 0 and address < DEPTH.
  - Allowed write: bytes with we[i] = 1 are updated; other bytes are unchanged; read_data <= 0.
  - Allowed read: read_data <= word[address].
  - Denied access: memory is unchanged; read_data <= 0; access_violation = 1 during ACK.
  - Then go to ACK.
- ACK:
  - ready = 1 for exactly one cycle; cs and zeroize are ignored.
  - Return to IDLE.
  - Latency is 1 cycle from cs sampled in IDLE to ready; throughput is one access per 2 cycles.
  - A master still holding cs in the following IDLE cycle starts a new access.
- zeroize asserted in ACK or CLEAR is dropped; a re-request must come after busy = 0.
- Reset asserted mid-sweep or mid-access:
  - Outputs return to reset values immediately.
  - The sweep restarts from address 0.
  - An in-flight write may or may not have been committed; it is never partial at byte granularity.
- Address compare is unsigned over ADDR_WIDTH bits; when DEPTH = 2**ADDR_WIDTH no address is out of range.

Optional Feature:
- Macro: FW_RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte and written together with that byte (including clear sweeps, where parity = 0).
  - On an allowed read, any byte whose parity mismatches forces read_data = 0 and pulses parity_error with ready.
  - Writes never report parity errors.
- Undefined:
  - No parity storage; parity_error is tied to 0.

Test Plan:
- Reset release, DEPTH = 512: busy = 1 for 512 cycles, then 0; read of address 0x1FF returns 0x00000000 with ready after 1 cycle.
- system_mode = 0, write 0xDEADBEEF to 0x010 with we = 4'hF; then write 0x000000AA with we = 4'b0001; read 0x010 -> 0xDEADBEAA, ready a single-cycle pulse.
- system_mode = 1, write 0x12345678 to 0x010 -> ready = 1 and access_violation = 1 in the same cycle; a later firmware read of 0x010 still returns 0xDEADBEAA; an application-mode read returns 0.
- DEPTH = 300, ADDR_WIDTH = 9, read 0x12C -> read_data = 0, access_violation = 1; write to 0x12B succeeds.
- Mid-sweep: cs read of 0x005 asserted at cycle 100 of a zeroize sweep -> ready only 1 cycle after busy falls, data = 0. Reset at sweep cycle 200 -> busy stays 1 for a full 512 new cycles.
- With FW_RAM_PARITY_EN: force-flip stored bit 9 of word 0x020 (written as 0x0000FF00) -> read gives read_data = 0 and parity_error = 1; rewrite the word -> clean read, parity_error = 0.

Source files
------------

// File: rtl/fw_ram_acl.sv
// fw_ram_acl: parametrised firmware RAM with per-byte write enables,
// registered read, firmware-only access control and hardware zeroization.
//
// Parameters:
//   DEPTH      number of words (2 .. 2**ADDR_WIDTH)
//   ADDR_WIDTH word address width
//   DATA_WIDTH word width, multiple of 8
//
// Ports:
//   clk              system clock
//   reset_n          asynchronous active-low reset
//   system_mode      0 = firmware (access allowed), 1 = application (denied)
//   cs               request strobe, held by the master until ready
//   we               per-byte write enables, all zero = read
//   address          word address
//   write_data       write data
//   zeroize          single-cycle request to clear the whole memory
//   read_data        registered read data, valid while ready = 1
//   ready            one-cycle acknowledge
//   busy             high while a clear sweep runs
//   access_violation one-cycle pulse with ready on a denied access
//   parity_error     one-cycle pulse with ready on a corrupted read
//
// Optional build macro FW_RAM_PARITY_EN: stores one even-parity bit per
// byte and checks it on reads. Without it parity_error is tied to 0.
//
// Handshake: a request is sampled when cs = 1 while the FSM is in IDLE;
// ready is asserted for exactly one cycle (state ACK) on the next cycle and
// cs is ignored during ACK. During CLEAR the request stays pending.
// state_q is the FSM state register and is the tap for bound checkers.
module fw_ram_acl #(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    system_mode,
  input  logic                    cs,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic                    zeroize,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    ready,
  output logic                    busy,
  output logic                    access_violation,
  output logic                    parity_error
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  // One extra bit so DEPTH = 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    start;
  logic                    clr_we;
  logic                    zeroize_ok;
  logic                    in_range;
  logic                    allowed;
  logic                    wr_en;
  logic                    rd_en;
  logic                    rd_ok;
  logic                    viol_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign zeroize_ok = zeroize & ~system_mode;
  assign in_range   = {1'b0, address} < DEPTH_W;
  assign allowed    = ~system_mode & in_range;
  assign wr_en      = start & allowed & (|we);
  assign rd_en      = start & allowed & ~(|we);

  // Next-state logic. zeroize wins over cs in IDLE; both are ignored in
  // ACK and CLEAR, so a dropped zeroize must be re-requested later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        if (zeroize_ok) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (cs) begin
          start   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage has no reset; the sweep after reset clears it. A write is a
  // single clock-edge update, so it is never split across bytes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (we[i]) mem[address][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

`ifdef FW_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] wr_par;
  logic [NB-1:0] rd_bad;
  logic          perr_q;

  // Even parity: stored bit makes the 9-bit group have an even count.
  always_comb begin
    wr_par = '0;
    rd_bad = '0;
    for (int i = 0; i < NB; i++) begin
      wr_par[i] = ^write_data[8*i +: 8];
      rd_bad[i] = (^mem[address][8*i +: 8]) ^ par_mem[address][i];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (we[i]) par_mem[address][i] <= wr_par[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perr_q <= 1'b0;
    else          perr_q <= rd_en & (|rd_bad);
  end

  assign rd_ok        = rd_en & ~(|rd_bad);
  assign parity_error = perr_q;
`else
  assign rd_ok        = rd_en;
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_CLEAR;
      cnt_q     <= '0;
      read_data <= '0;
      viol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      viol_q  <= start & ~allowed;
      // Writes, denied accesses and corrupted reads all return zero.
      if (start) read_data <= rd_ok ? mem[address] : '0;
    end
  end

  assign ready            = (state_q == S_ACK);
  assign busy             = (state_q == S_CLEAR);
  assign access_violation = viol_q;

endmodule

// File: tb/tb_fw_ram_acl.sv
module tb_fw_ram_acl;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        system_mode;
  logic        cs;
  logic [3:0]  we;
  logic [8:0]  address;
  logic [31:0] write_data;
  logic        zeroize;

  logic [31:0] read_data;
  logic        ready, busy, access_violation, parity_error;
  logic [31:0] r2_data;
  logic        r2_ready, r2_busy, r2_av, r2_pe;

  always #5 clk = ~clk;

  fw_ram_acl #(.DEPTH(512), .ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .system_mode(system_mode), .cs(cs),
    .we(we), .address(address), .write_data(write_data), .zeroize(zeroize),
    .read_data(read_data), .ready(ready), .busy(busy),
    .access_violation(access_violation), .parity_error(parity_error)
  );

  // Short-depth instance sharing the same bus, for out-of-range checks.
  fw_ram_acl #(.DEPTH(300), .ADDR_WIDTH(9), .DATA_WIDTH(32)) dut300 (
    .clk(clk), .reset_n(reset_n), .system_mode(system_mode), .cs(cs),
    .we(we), .address(address), .write_data(write_data), .zeroize(zeroize),
    .read_data(r2_data), .ready(r2_ready), .busy(r2_busy),
    .access_violation(r2_av), .parity_error(r2_pe)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  exp_f_q[$];   // {access_violation, parity_error}
  logic [31:0] model [512];
  int          cap_lat;
  logic [31:0] cap2_rdata;
  logic        cap2_av;
  logic        cap2_pe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] w);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (w[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic do_access(input string name, input logic mode, input logic [3:0] w,
                           input logic [8:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input logic exp_av, input logic exp_pe);
    logic [31:0] e_rd;
    logic [1:0]  e_f;
    @(posedge clk); #1;
    system_mode = mode; cs = 1'b1; we = w; address = a; write_data = d;
    exp_q.push_back(exp_rd);
    exp_f_q.push_back({exp_av, exp_pe});
    cap_lat = 0;
    do begin
      @(posedge clk); #1;
      cap_lat++;
    end while (!ready && cap_lat < 1500);
    cap2_rdata = r2_data; cap2_av = r2_av; cap2_pe = r2_pe;
    check({name, " ready"}, 32'(ready), 32'd1);
    e_rd = exp_q.pop_front();
    e_f  = exp_f_q.pop_front();
    check({name, " rdata"}, read_data, e_rd);
    check({name, " viol"}, 32'(access_violation), 32'(e_f[1]));
    check({name, " perr"}, 32'(parity_error), 32'(e_f[0]));
    cs = 1'b0; we = 4'h0;
    @(posedge clk); #1;
    check({name, " ready pulse"}, 32'(ready), 32'd0);
  endtask

  task automatic count_sweep(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 2000);
    check(name, n, 512);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        mode;
    logic [3:0]  w;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_av;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, fall;
    logic        m;
    logic [3:0]  w;
    logic [8:0]  a;
    logic [31:0] d, e;
    logic [31:0] e_rd;
    logic [1:0]  e_f;

    vecs[0]  = '{1'b0, 4'h0, 9'h1FF, 32'h0,        32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 4'hF, 9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 4'h1, 9'h010, 32'h000000AA, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 9'h010, 32'h0,        32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b1, 4'hF, 9'h010, 32'h12345678, 32'h00000000, 1'b1};
    vecs[5]  = '{1'b0, 4'h0, 9'h010, 32'h0,        32'hDEADBEAA, 1'b0};
    vecs[6]  = '{1'b1, 4'h0, 9'h010, 32'h0,        32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, 4'h6, 9'h011, 32'hAABBCCDD, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b0, 4'h0, 9'h011, 32'h0,        32'h00BBCC00, 1'b0};
    vecs[9]  = '{1'b0, 4'h8, 9'h011, 32'h11223344, 32'h00000000, 1'b0};
    vecs[10] = '{1'b0, 4'h0, 9'h011, 32'h0,        32'h11BBCC00, 1'b0};
    vecs[11] = '{1'b0, 4'hF, 9'h1FF, 32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[12] = '{1'b0, 4'h0, 9'h1FF, 32'h0,        32'hCAFEF00D, 1'b0};

    for (int i = 0; i < 512; i++) model[i] = 32'h0;

    // reset state
    reset_n = 1'b0; system_mode = 1'b0; cs = 1'b0; we = 4'h0;
    address = 9'h0; write_data = 32'h0; zeroize = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(ready), 32'd0);
    check("reset rdata", read_data, 32'h0);
    check("reset viol", 32'(access_violation), 32'd0);
    check("reset perr", 32'(parity_error), 32'd0);
    check("reset busy", 32'(busy), 32'd1);
    reset_n = 1'b1;
    count_sweep("init sweep cycles");
    check("dut300 sweep done", 32'(r2_busy), 32'd0);

    // table-driven accesses
    for (int i = 0; i < 13; i++) begin
      do_access($sformatf("vec%0d", i), vecs[i].mode, vecs[i].w, vecs[i].a, vecs[i].d,
                vecs[i].exp_rd, vecs[i].exp_av, 1'b0);
      check($sformatf("vec%0d latency", i), cap_lat, 1);
      if (!vecs[i].mode) model[vecs[i].a] = merge(model[vecs[i].a], vecs[i].d, vecs[i].w);
    end

    // random traffic against a word model
    for (int i = 0; i < 40; i++) begin
      a = 9'($urandom_range(0, 63));
      m = ($urandom_range(0, 7) == 0);
      w = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) w = 4'h0;
      d = $urandom;
      e = (m || w != 4'h0) ? 32'h0 : model[a];
      do_access($sformatf("rnd%0d", i), m, w, a, d, e, m, 1'b0);
      if (!m) model[a] = merge(model[a], d, w);
    end

    // DEPTH = 300 boundary
    do_access("d512 rd 12C", 1'b0, 4'h0, 9'h12C, 32'h0, model[9'h12C], 1'b0, 1'b0);
    check("d300 rd 12C rdata", cap2_rdata, 32'h0);
    check("d300 rd 12C viol", 32'(cap2_av), 32'd1);
    do_access("wr 12B", 1'b0, 4'hF, 9'h12B, 32'h0BADF00D, 32'h0, 1'b0, 1'b0);
    model[9'h12B] = 32'h0BADF00D;
    check("d300 wr 12B viol", 32'(cap2_av), 32'd0);
    do_access("rd 12B", 1'b0, 4'h0, 9'h12B, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);
    check("d300 rd 12B rdata", cap2_rdata, 32'h0BADF00D);
    check("d300 rd 12B perr", 32'(cap2_pe), 32'd0);

    // application-mode zeroize is ignored
    do_access("wr 005", 1'b0, 4'hF, 9'h005, 32'h55AA55AA, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    zeroize = 1'b1; system_mode = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0; system_mode = 1'b0;
    check("app zeroize busy", 32'(busy), 32'd0);
    do_access("rd 005 kept", 1'b0, 4'h0, 9'h005, 32'h0, 32'h55AA55AA, 1'b0, 1'b0);

    // read held pending across a zeroize sweep
    @(posedge clk); #1;
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    check("zeroize busy", 32'(busy), 32'd1);
    repeat (99) @(posedge clk);
    #1;
    cs = 1'b1; we = 4'h0; address = 9'h005;
    exp_q.push_back(32'h0);
    exp_f_q.push_back(2'b00);
    cyc = 0; fall = -1;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!busy && fall < 0) fall = cyc;
    end while (!ready && cyc < 1500);
    check("pend ready", 32'(ready), 32'd1);
    check("pend ready after busy", cyc - fall, 1);
    e_rd = exp_q.pop_front();
    e_f  = exp_f_q.pop_front();
    check("pend rdata", read_data, e_rd);
    check("pend viol", 32'(access_violation), 32'(e_f[1]));
    cs = 1'b0;
    for (int i = 0; i < 512; i++) model[i] = 32'h0;
    repeat (3) @(posedge clk);

    // reset in the middle of a sweep restarts it from zero
    do_access("wr 007", 1'b0, 4'hF, 9'h007, 32'h01234567, 32'h0, 1'b0, 1'b0);
    do_access("rd 007", 1'b0, 4'h0, 9'h007, 32'h0, 32'h01234567, 1'b0, 1'b0);
    @(posedge clk); #1;
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd1);
    check("midreset rdata", read_data, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    count_sweep("midreset sweep cycles");
    do_access("rd 007 cleared", 1'b0, 4'h0, 9'h007, 32'h0, 32'h0, 1'b0, 1'b0);

`ifdef FW_RAM_PARITY_EN
    do_access("par wr", 1'b0, 4'hF, 9'h020, 32'h0000FF00, 32'h0, 1'b0, 1'b0);
    dut.mem[32][9] = ~dut.mem[32][9];
    do_access("par bad rd", 1'b0, 4'h0, 9'h020, 32'h0, 32'h0, 1'b0, 1'b1);
    do_access("par rewr", 1'b0, 4'hF, 9'h020, 32'h0000FF00, 32'h0, 1'b0, 1'b0);
    do_access("par good rd", 1'b0, 4'h0, 9'h020, 32'h0, 32'h0000FF00, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
